music_box_ctrl: RTL
===================

# music_box_ctrl

Playback controller for the music box. It generates the beat tick, sequences the beat index through play, pause and stop, and latches the song selection. It also shares the single stereo tone output between the music-box ROM and the live keyboard, with the keyboard always taking priority. It sits between the debounced button/keyboard front end and the tone generators, and drives the beat index into the music ROM.

## Interface
Parameters:
- SONG_LEN, 128: beats per song; ibeat ranges 0..SONG_LEN-1 (≤256)
- KEY_HOLDOFF, 4: beats of box silence after a live key is released

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- beat_div  in  32  clk cycles per beat; values <2 are treated as 2
- play_btn  in  1  single-cycle pulse; play/pause toggle
- stop_btn  in  1  single-cycle pulse
- song_sel  in  2  requested song
- key_valid  in  1  live keyboard note held
- key_freq  in  32  live note frequency
- box_freq  in  32  right tone from music ROM (combinational on ibeat)
- box_left_freq  in  32  left tone from music ROM
- ibeat  out  8  beat index to music ROM
- song_id  out  2  latched song to music ROM
- tone_right  out  32  right tone to tone generator
- tone_left  out  32  left tone to tone generator
- playing  out  1  state==PLAY
- paused  out  1  state==PAUSE
- beat_tick  out  1  one-cycle pulse at each beat boundary

## Operation
- Reset: state STOP; all outputs 0; divider and holdoff counter 0.
- FSM states: STOP, PLAY, PAUSE.
  - STOP + play_btn -> PLAY. ibeat=0, divider=0, song_id<=song_sel.
  - PLAY + play_btn -> PAUSE. ibeat and divider frozen.
  - PAUSE + play_btn -> PLAY. Resumes from the frozen count.
  - Any state + stop_btn -> STOP. ibeat=0, divider=0, holdoff=0.
  - stop_btn and play_btn in the same cycle: stop wins.
- song_sel is sampled only on STOP->PLAY. Changes during PLAY or PAUSE are ignored.
- Divider runs only in PLAY and counts 0..D-1, where D=max(beat_div,2).
  - beat_tick=1 in the cycle where the counter is at D-1; the counter then wraps to 0.
  - If beat_div shrinks mid-beat so that counter ≥ D-1, tick on the next cycle and wrap.
- ibeat advances by 1 on each beat_tick. End of song is a tick at ibeat=SONG_LEN-1 (see Configuration).
- Output arbitration (priority order):
  1. key_valid=1 -> both tones = key_freq, in any state.
  2. holdoff>0, or state≠PLAY -> both tones = 0.
  3. Otherwise tone_right=box_freq, tone_left=box_left_freq.
- Holdoff:
  - Falling edge of key_valid loads KEY_HOLDOFF.
  - Decrements on each beat_tick, saturating at 0.
  - A key press during holdoff preempts it; the next release reloads it.
- The box keeps advancing ibeat while the keyboard owns the output, so the song stays on tempo.

## Timing
- beat_tick and ibeat are registered. ibeat shows the new value the cycle after beat_tick.
- tone_right/tone_left are registered with 1-cycle latency from key_valid/key_freq/box_* and from state changes.
- playing/paused are registered and update the cycle after the button pulse.
- First beat_tick after STOP->PLAY comes D cycles after the play_btn cycle.

## Configuration
- MUSIC_BOX_LOOP_EN defined: a tick at ibeat=SONG_LEN-1 wraps ibeat to 0 and stays in PLAY.
- Not defined: that tick moves to STOP with ibeat=0. playing falls the next cycle, and the tones go silent unless a key is held.

## Structure
- Shared package music_pkg: state enum (STOP, PLAY, PAUSE), SILENCE=32'd0, width constants.
- Sub-module beat_divider handles the divider counter and tick. It takes clk, reset, run, clear and div, and produces tick.
- Remaining logic in the top module: FSM, ibeat, holdoff, output mux.

## Test plan
- Reset, beat_div=4, play_btn -> first beat_tick 4 cycles later; ibeat 0,1,2 on consecutive 4-cycle beats; tones follow box_* with 1-cycle lag.
- At ibeat=5, play_btn -> PAUSE, tones 0, ibeat holds 5 for 20 cycles; play_btn -> resumes, next tick after the remaining divider count.
- key_valid=1, key_freq=440 during PLAY -> tones 440 next cycle, ibeat keeps advancing; release -> tones 0 for exactly 4 ticks, then box_* again.
- play_btn and stop_btn in the same cycle during PLAY -> STOP, ibeat=0, playing=0.
- SONG_LEN=8: with MUSIC_BOX_LOOP_EN, ibeat goes 7->0 and playing stays 1; without it, STOP after the 8th tick.
- song_sel=2 at play, changed to 1 mid-song -> song_id stays 2 until stop, then play latches 1.

Source files
------------

// File: rtl/music_pkg.sv
// ============================================================================
//  Module      : music_pkg
//  Description : Shared types and constants for the music box playback
//                controller: FSM state encoding, silence code, datapath
//                widths and the divider terminal-count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package music_pkg;

    localparam int FREQ_W = 32;
    localparam int DIV_W  = 32;
    localparam int BEAT_W = 8;
    localparam int SONG_W = 2;
    localparam int HOLD_W = 8;

    localparam logic [FREQ_W-1:0] SILENCE = 32'd0;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Terminal count of the beat divider; divisors below 2 behave as 2.
    function automatic logic [DIV_W-1:0] last_count(input logic [DIV_W-1:0] div);
        return (div < DIV_W'(2)) ? DIV_W'(1) : (div - DIV_W'(1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/beat_divider.sv
// ============================================================================
//  Module      : beat_divider
//  Description : Beat clock divider. Counts clk cycles 0..D-1 while run is
//                high and pulses tick while the count sits at D-1. The tick
//                flag is precomputed one edge early so it comes straight
//                from flops; it is gated with run so a count frozen at D-1
//                during pause only ticks once playback resumes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_divider
    import music_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last;
    logic             at_last;

    assign last = last_count(div);

    // Beat counter: wrap after the terminal cycle, otherwise advance and flag
    // when the next value reaches (or, after a shrink, overshoots) the end.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count   <= '0;
            at_last <= 1'b0;
        end else if (run) begin
            if (at_last) begin
                count   <= '0;
                at_last <= 1'b0;
            end else begin
                count   <= count + DIV_W'(1);
                at_last <= ((count + DIV_W'(1)) >= last);
            end
        end
    end

    assign tick = at_last & run;

endmodule

`default_nettype wire

// File: rtl/music_box_ctrl.sv
// ============================================================================
//  Module      : music_box_ctrl
//  Description : Music box playback controller. Play/pause/stop FSM, beat
//                index sequencing, song latch, and arbitration of the stereo
//                tone output between the ROM and the live keyboard (keyboard
//                first, followed by a short silent holdoff after release).
//  Config      : MUSIC_BOX_LOOP_EN - when defined the song wraps to beat 0
//                and keeps playing; otherwise the last beat stops playback.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module music_box_ctrl
    import music_pkg::*;
#(
    parameter int SONG_LEN    = 128,
    parameter int KEY_HOLDOFF = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIV_W-1:0]  beat_div,
    input  logic              play_btn,
    input  logic              stop_btn,
    input  logic [SONG_W-1:0] song_sel,
    input  logic              key_valid,
    input  logic [FREQ_W-1:0] key_freq,
    input  logic [FREQ_W-1:0] box_freq,
    input  logic [FREQ_W-1:0] box_left_freq,
    output logic [BEAT_W-1:0] ibeat,
    output logic [SONG_W-1:0] song_id,
    output logic [FREQ_W-1:0] tone_right,
    output logic [FREQ_W-1:0] tone_left,
    output logic              playing,
    output logic              paused,
    output logic              beat_tick
);

`ifdef MUSIC_BOX_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SONG_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(KEY_HOLDOFF);

    state_t            state;
    state_t            state_nxt;
    logic              tick;
    logic              div_clear;
    logic              song_end;
    logic              key_prev;
    logic              key_release;
    logic [HOLD_W-1:0] holdoff;

    // Divider is held at zero while stopped so a fresh play starts a full beat.
    assign div_clear   = stop_btn || (state == ST_STOP);
    assign song_end    = tick && (ibeat == LAST_BEAT);
    assign key_release = key_prev && !key_valid;

    beat_divider u_beat_divider (
        .clk   (clk),
        .reset (reset),
        .run   (state == ST_PLAY),
        .clear (div_clear),
        .div   (beat_div),
        .tick  (tick)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_STOP;
        else       state <= state_nxt;
    end

    // FSM next state: stop dominates; the final beat ends playback unless looping.
    always_comb begin
        state_nxt = state;
        if (stop_btn) begin
            state_nxt = ST_STOP;
        end else begin
            case (state)
                ST_STOP:  if (play_btn) state_nxt = ST_PLAY;
                ST_PLAY: begin
                    if (song_end && !LOOP_EN) state_nxt = ST_STOP;
                    else if (play_btn)        state_nxt = ST_PAUSE;
                end
                ST_PAUSE: if (play_btn) state_nxt = ST_PLAY;
                default:  state_nxt = ST_STOP;
            endcase
        end
    end

    // Beat index: zero while stopped, advance on each beat, wrap after the last.
    always_ff @(posedge clk) begin
        if (reset || stop_btn || (state == ST_STOP)) begin
            ibeat <= '0;
        end else if (tick) begin
            ibeat <= (ibeat == LAST_BEAT) ? '0 : (ibeat + BEAT_W'(1));
        end
    end

    // Song selection is captured only when playback starts from stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            song_id <= '0;
        end else if ((state == ST_STOP) && play_btn && !stop_btn) begin
            song_id <= song_sel;
        end
    end

    // Keyboard release holdoff, counted down in beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev <= 1'b0;
            holdoff  <= '0;
        end else begin
            key_prev <= key_valid;
            if (stop_btn)                       holdoff <= '0;
            else if (key_release)               holdoff <= HOLD_LOAD;
            else if (tick && (holdoff != '0))   holdoff <= holdoff - HOLD_W'(1);
        end
    end

    // Output tone mux; the release cycle itself already counts as silent.
    always_ff @(posedge clk) begin
        if (reset) begin
            tone_right <= SILENCE;
            tone_left  <= SILENCE;
        end else if (key_valid) begin
            tone_right <= key_freq;
            tone_left  <= key_freq;
        end else if (key_release || (holdoff != '0) || (state != ST_PLAY)) begin
            tone_right <= SILENCE;
            tone_left  <= SILENCE;
        end else begin
            tone_right <= box_freq;
            tone_left  <= box_left_freq;
        end
    end

    assign playing   = (state == ST_PLAY);
    assign paused    = (state == ST_PAUSE);
    assign beat_tick = tick;

endmodule

`default_nettype wire
